// File: rtl/word_packer.sv
// word_packer: packs IN_W-bit beats into WIDTH-bit words; in_last flushes a zero-padded partial word.
// Latency 1 cycle from the closing beat to out_valid; in_ready = !out_valid | out_ready (no input accepted while a word stalls).
// Optional macro WORD_PACKER_MSB_FIRST_EN places beat 0 in the top slot instead of the bottom slot.
module word_packer #(
    parameter  int WIDTH = 10,
    parameter  int IN_W  = 2,
    localparam int RATIO = WIDTH / IN_W,
    localparam int BW    = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [BW-1:0]    out_beats,
    output logic [15:0]      word_cnt
);

    localparam logic [BW-1:0] LAST_SLOT = BW'(RATIO - 1);

    logic [BW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [BW-1:0]    out_beats_q, out_beats_d;
    logic [15:0]      word_cnt_q, word_cnt_d;

    logic             in_acc;
    logic             out_acc;
    logic             closing;
    int               slot_sh;
    logic [WIDTH-1:0] beat_word;

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        in_acc   = in_valid && in_ready;
        out_acc  = out_valid_q && out_ready;
        closing  = in_acc && (in_last || (cnt_q == LAST_SLOT));

`ifdef WORD_PACKER_MSB_FIRST_EN
        slot_sh = WIDTH - IN_W - int'(cnt_q) * IN_W;
`else
        slot_sh = int'(cnt_q) * IN_W;
`endif
        beat_word = WIDTH'(in_data) << slot_sh;

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_beats_d = out_beats_q;
        word_cnt_d  = word_cnt_q;

        // in_acc implies the output register is free or draining this cycle,
        // so a close may always overwrite it.
        if (closing) begin
            out_data_d  = acc_q | beat_word;
            out_beats_d = cnt_q + BW'(1);
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            acc_d       = '0;
        end else begin
            if (in_acc) begin
                cnt_d = cnt_q + BW'(1);
                acc_d = acc_q | beat_word;
            end
            if (out_acc) begin
                out_valid_d = 1'b0;
            end
        end

        if (out_acc && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_beats_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_beats_q <= out_beats_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_beats = out_beats_q;
    assign word_cnt  = word_cnt_q;

endmodule
